disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Scan controller for the board's 3-digit multiplexed 7-segment display (`seg[7:0]` segments, `baza[2:0]` digit-driver transistor bases). It holds a displayed 3-digit hex value plus decimal points, time-multiplexes the digits at a rate set by a prescaler, and blanks the display between digits to stop ghosting. New values pass through a tear-free load handshake: they are accepted at any time but applied only at a frame boundary. It sits between the application logic and the display pins, replacing ad-hoc per-design scan counters.

## Interface
- `DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK`, default 500: cycles blanked at the start of each slot; legal range 1 ≤ BLANK < DIV.
- `iCLK`  in  1  system clock; all logic on the rising edge.
- `iRST`  in  1  asynchronous, active-high reset.
- `iLOAD`  in  1  single-cycle request to load `iDATA`/`iDP`; sampled only while `oREADY`=1.
- `iDATA`  in  12  three hex digits; `[3:0]` is digit 0 (rightmost, `baza[0]`), `[11:8]` is digit 2.
- `iDP`  in  3  decimal points; bit n lights the dp of digit n.
- `oREADY`  out  1  high when the pending buffer is empty and a load can be accepted.
- `oFRAME`  out  1  one-cycle pulse on the cycle a pending value is committed to the display.
- `seg`  out  8  segment drive, active-low; `seg[6:0]` = g..a, `seg[7]` = dp.
- `baza`  out  3  digit enables, active-low and one-hot when a digit is lit.

## Operation
- Slot counter `cnt` runs 0..DIV-1 and wraps. On wrap, digit index `dig` advances 0→1→2→0.
- Frame end is the cycle where `cnt`=DIV-1 and `dig`=2.
- Per-slot phases:
  - BLANK phase, `cnt` < BLANK: `seg`=8'hFF, `baza`=3'b111.
  - SHOW phase, `cnt` ≥ BLANK: `baza` drives only bit `dig` low, and `seg` shows the decoded shadow nibble for `dig`. `seg[7]`=~shadow_dp[dig].
- Decode, active-low `seg[6:0]`, standard hex:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - With dp off, `seg` is therefore 0xC0, 0xF9, 0xA4, 0xB0, ….
- Load handshake:
  - `iLOAD`=1 while `oREADY`=1 captures `iDATA`/`iDP` into the pending register. `oREADY` goes to 0 from the next cycle.
  - `iLOAD` while `oREADY`=0 is ignored. The pending value is not overwritten.
- Commit: at the frame-end edge with pending valid, shadow ← pending and pending is cleared. `oFRAME`=1 and `oREADY`=1 in the following cycle.
- Simultaneous `iLOAD` (with `oREADY`=1) and frame end: the data is captured into pending. It is committed at the next frame end, not this one.
- Reset mid-operation: all state returns to reset values immediately and asynchronously. Any pending load is discarded.

## Timing
- Reset values:
  - outputs: `seg`=8'hFF, `baza`=3'b111, `oREADY`=1, `oFRAME`=0
  - internal: `cnt`=0, `dig`=0, shadow data=12'h000, shadow dp=3'b000, pending empty
- `seg`, `baza` and `oFRAME` are registered, so each lags the internal `cnt`/`dig` state by exactly one cycle.
  - The first output cycle after reset release shows BLANK for digit 0.
  - After reset, once BLANK completes, digit 0 shows "0" (`seg`=8'hC0, `baza`=3'b110).
- Slot length is DIV cycles: BLANK cycles dark, then DIV-BLANK cycles lit. Frame length is 3·DIV cycles.
- Load-to-visible latency is bounded by 3·DIV+BLANK+1 cycles. The new value first appears on digit 0 of the frame after commit.
- `baza` never has more than one bit low. No cycle has `baza`≠3'b111 together with a segment pattern belonging to a different digit.

## Test plan
All scenarios use DIV=8, BLANK=2, a 20 ns clock period, and `iRST` held for 100 ns.
- Reset: during and after `iRST`, `seg`=FF, `baza`=111, `oREADY`=1. The first frame shows "000": 2 blank cycles, then 6 cycles of C0/110, then the same for 101 and 011.
- Load: `iLOAD` with `iDATA`=12'h123, `iDP`=0 → `oREADY`=0 next cycle. One `oFRAME` pulse at frame end. The next frame shows B0/110, A4/101, F9/011, each for 6 cycles after 2 blank cycles.
- Busy load: a second `iLOAD` with 12'hABC while `oREADY`=0 → ignored. The display shows 123, and `oREADY` returns to 1 only after that single commit.
- Decimal point and full decode: load 12'hF8E with `iDP`=3'b101 → digit 0 shows 06 with dp lit (0x06), digit 1 shows 80, digit 2 shows 0E with dp lit (0x0E). Repeat with loads covering all 16 nibbles against the decode list.
- Boundary: assert `iLOAD` exactly on the frame-end cycle → no `oFRAME` pulse at that edge; `oFRAME` pulses 24 cycles later and the value becomes visible then.
- Reset mid-slot: assert `iRST` while digit 1 is lit with a load pending → `seg`=FF, `baza`=111 and `oREADY`=1 immediately. After release, the display shows "000".

Source files
------------

// File: rtl/disp_scan_ctrl_if.sv
// Load handshake between application logic and the display scan controller.
// The master (application) offers a value; the slave (controller) reports readiness and frame commits.
interface disp_scan_ctrl_if;
  logic        iLOAD;
  logic [11:0] iDATA;
  logic [2:0]  iDP;
  logic        oREADY;
  logic        oFRAME;

  modport master (
    output iLOAD,
    output iDATA,
    output iDP,
    input  oREADY,
    input  oFRAME
  );

  modport slave (
    input  iLOAD,
    input  iDATA,
    input  iDP,
    output oREADY,
    output oFRAME
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Three-digit multiplexed 7-segment scan controller with inter-digit blanking
// and a tear-free load path that only updates the shown value at frame boundaries.
module disp_scan_ctrl #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic             iCLK,
  input  logic             iRST,
  disp_scan_ctrl_if.slave  bus,
  output logic [7:0]       seg,
  output logic [2:0]       baza
);

  localparam int             CW        = $clog2(DIV);
  localparam logic [CW-1:0]  CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0]  CNT_BLANK = CW'(BLANK);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

  // Active-low segment pattern (g..a) for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0: pat = 7'h40;
      4'h1: pat = 7'h79;
      4'h2: pat = 7'h24;
      4'h3: pat = 7'h30;
      4'h4: pat = 7'h19;
      4'h5: pat = 7'h12;
      4'h6: pat = 7'h02;
      4'h7: pat = 7'h78;
      4'h8: pat = 7'h00;
      4'h9: pat = 7'h10;
      4'hA: pat = 7'h08;
      4'hB: pat = 7'h03;
      4'hC: pat = 7'h46;
      4'hD: pat = 7'h21;
      4'hE: pat = 7'h06;
      default: pat = 7'h0E;
    endcase
    return pat;
  endfunction

  logic [CW-1:0] cnt_q,          cnt_d;
  logic [1:0]    dig_q,          dig_d;
  logic [11:0]   shadow_data_q,  shadow_data_d;
  logic [2:0]    shadow_dp_q,    shadow_dp_d;
  logic [11:0]   pend_data_q,    pend_data_d;
  logic [2:0]    pend_dp_q,      pend_dp_d;
  logic          pend_valid_q,   pend_valid_d;
  logic [7:0]    seg_q,          seg_d;
  logic [2:0]    baza_q,         baza_d;
  logic          frame_q,        frame_d;

  logic          slot_end;
  logic          frame_end;
  logic          commit;
  logic          accept;
  logic          show;
  logic [3:0]    nib_arr [3];
  logic [2:0]    digit_sel_n;
  logic [3:0]    cur_nib;
  logic          cur_dp;

  for (genvar gi = 0; gi < 3; gi++) begin : g_digit
    assign nib_arr[gi]     = shadow_data_q[4*gi +: 4];
    assign digit_sel_n[gi] = (dig_q != 2'(gi));
  end

  always_comb begin
    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (dig_q == 2'd2);
    commit    = frame_end && pend_valid_q;
    // A pending value blocks new loads until it has been committed.
    accept    = bus.iLOAD && !pend_valid_q;
    show      = (cnt_q >= CNT_BLANK);

    cnt_d = slot_end ? '0 : cnt_q + CNT_ONE;
    dig_d = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == 2'd2) ? 2'd0 : dig_q + 2'd1;
    end

    cur_nib = nib_arr[0];
    cur_dp  = shadow_dp_q[0];
    case (dig_q)
      2'd1: begin
        cur_nib = nib_arr[1];
        cur_dp  = shadow_dp_q[1];
      end
      2'd2: begin
        cur_nib = nib_arr[2];
        cur_dp  = shadow_dp_q[2];
      end
      default: begin
        cur_nib = nib_arr[0];
        cur_dp  = shadow_dp_q[0];
      end
    endcase

    shadow_data_d = shadow_data_q;
    shadow_dp_d   = shadow_dp_q;
    pend_data_d   = pend_data_q;
    pend_dp_d     = pend_dp_q;
    pend_valid_d  = pend_valid_q;
    if (commit) begin
      shadow_data_d = pend_data_q;
      shadow_dp_d   = pend_dp_q;
      pend_valid_d  = 1'b0;
    end else if (accept) begin
      pend_data_d  = bus.iDATA;
      pend_dp_d    = bus.iDP;
      pend_valid_d = 1'b1;
    end

    frame_d = commit;
    seg_d   = show ? {~cur_dp, hex7(cur_nib)} : 8'hFF;
    baza_d  = show ? digit_sel_n : 3'b111;
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      cnt_q         <= '0;
      dig_q         <= 2'd0;
      shadow_data_q <= 12'h000;
      shadow_dp_q   <= 3'b000;
      pend_data_q   <= 12'h000;
      pend_dp_q     <= 3'b000;
      pend_valid_q  <= 1'b0;
      seg_q         <= 8'hFF;
      baza_q        <= 3'b111;
      frame_q       <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      dig_q         <= dig_d;
      shadow_data_q <= shadow_data_d;
      shadow_dp_q   <= shadow_dp_d;
      pend_data_q   <= pend_data_d;
      pend_dp_q     <= pend_dp_d;
      pend_valid_q  <= pend_valid_d;
      seg_q         <= seg_d;
      baza_q        <= baza_d;
      frame_q       <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign baza       = baza_q;
  assign bus.oREADY = ~pend_valid_q;
  assign bus.oFRAME = frame_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed-plus-random bench for disp_scan_ctrl (DIV=8, BLANK=2) against a
// timeline model: slot/digit are derived arithmetically from cycles since reset.
module tb_disp_scan_ctrl;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 3 * DIV;

  logic       clk;
  logic       rst;
  logic [7:0] seg;
  logic [2:0] baza;

  disp_scan_ctrl_if bus ();

  disp_scan_ctrl #(.DIV(DIV), .BLANK(BLANK)) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus),
    .seg  (seg),
    .baza (baza)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [6:0] seg7_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_vec = 0;
  int n_err = 0;

  // Model: edges since reset release, shown value, and a one-entry pending slot.
  int          n_edges;
  logic [11:0] sh_data_m;
  logic [2:0]  sh_dp_m;
  logic [11:0] pd_data_m;
  logic [2:0]  pd_dp_m;
  bit          pv_m;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s at t=%0t: observed=%h expected=%h", tag, $time, obs, expv);
    end
  endtask

  task automatic model_reset();
    n_edges   = 0;
    sh_data_m = 12'h000;
    sh_dp_m   = 3'b000;
    pv_m      = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seg"},   12'(seg),        12'h0FF);
    chk({tag, "_baza"},  12'(baza),       12'h007);
    chk({tag, "_ready"}, 12'(bus.oREADY), 12'h001);
    chk({tag, "_frame"}, 12'(bus.oFRAME), 12'h000);
  endtask

  task automatic tick();
    int         p;
    int         d;
    logic [7:0] e_seg;
    logic [2:0] e_baza;
    bit         e_frame;
    logic [3:0] nib;
    @(posedge clk);
    p = n_edges % DIV;
    d = (n_edges / DIV) % 3;
    if (p < BLANK) begin
      e_seg  = 8'hFF;
      e_baza = 3'b111;
    end else begin
      nib    = 4'((sh_data_m >> (4 * d)) & 12'hF);
      e_seg  = {~sh_dp_m[d], seg7_tab[nib]};
      e_baza = ~(3'b001 << d);
    end
    e_frame = (p == DIV - 1) && (d == 2) && pv_m;
    if (e_frame) begin
      sh_data_m = pd_data_m;
      sh_dp_m   = pd_dp_m;
      pv_m      = 0;
    end else if (bus.iLOAD && !pv_m) begin
      pd_data_m = bus.iDATA;
      pd_dp_m   = bus.iDP;
      pv_m      = 1;
    end
    n_edges++;
    #1;
    chk("seg",   12'(seg),        12'(e_seg));
    chk("baza",  12'(baza),       12'(e_baza));
    chk("frame", 12'(bus.oFRAME), 12'(e_frame));
    chk("ready", 12'(bus.oREADY), 12'(!pv_m));
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (pv_m && guard < 4 * FRAME) begin
      tick();
      guard++;
    end
    chk("empty_timeout", 12'(pv_m), 12'h000);
  endtask

  task automatic tick_until_phase(input int ph);
    for (int k = 0; k < FRAME && (n_edges % FRAME) != ph; k++) tick();
  endtask

  task automatic do_load(input logic [11:0] data, input logic [2:0] dp);
    wait_empty();
    bus.iLOAD = 1'b1;
    bus.iDATA = data;
    bus.iDP   = dp;
    tick();
    bus.iLOAD = 1'b0;
  endtask

  logic [11:0] sweep [6] = '{12'h210, 12'h543, 12'h876, 12'hBA9, 12'hEDC, 12'hF0F};

  initial begin
    rst       = 1'b1;
    bus.iLOAD = 1'b0;
    bus.iDATA = 12'h000;
    bus.iDP   = 3'b000;
    model_reset();

    #25 chk_idle("rst_a");
    #30 chk_idle("rst_b");
    #45 rst = 1'b0;

    // First frame after reset shows "000".
    repeat (FRAME + 4) tick();

    // Basic load, then a load attempt while busy that must be dropped.
    do_load(12'h123, 3'b000);
    repeat (3) tick();
    bus.iLOAD = 1'b1;
    bus.iDATA = 12'hABC;
    bus.iDP   = 3'b111;
    tick();
    bus.iLOAD = 1'b0;
    repeat (2 * FRAME + 4) tick();

    // Decimal points and the full decode table.
    do_load(12'hF8E, 3'b101);
    repeat (2 * FRAME + 2) tick();
    for (int i = 0; i < 6; i++) begin
      do_load(sweep[i], 3'($urandom));
      repeat (2 * FRAME) tick();
    end

    // Load presented exactly on the frame-end edge is held for a full frame.
    wait_empty();
    tick_until_phase(FRAME - 1);
    bus.iLOAD = 1'b1;
    bus.iDATA = 12'h5A7;
    bus.iDP   = 3'b010;
    tick();
    bus.iLOAD = 1'b0;
    repeat (2 * FRAME + 4) tick();

    // Randomized loads at arbitrary phases.
    repeat (400) begin
      bus.iLOAD = ($urandom_range(0, 9) == 0);
      bus.iDATA = 12'($urandom);
      bus.iDP   = 3'($urandom);
      tick();
    end
    bus.iLOAD = 1'b0;
    repeat (FRAME) tick();

    // Asynchronous reset while digit 1 is lit and a load is pending.
    wait_empty();
    tick_until_phase(0);
    do_load(12'h9C4, 3'b011);
    tick_until_phase(12);
    chk("pend_before_rst", 12'(bus.oREADY), 12'h000);
    #3 rst = 1'b1;
    #1 chk_idle("rst_mid");
    repeat (5) @(negedge clk);
    chk_idle("rst_hold");
    rst = 1'b0;
    model_reset();
    repeat (FRAME + 8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
